fu_logic_pipe: RTL
==================

# fu_logic_pipe

Pipelined, multi-operation bitwise functional unit for the superscalar execute stage. It generalises the single-op AND unit in several ways: it selects among eight logic operations per issue, has a parametrised data width and latency, and carries an issue tag through to writeback. It accepts one operation per cycle under a valid/ready handshake in both directions, with output backpressure and a pipeline flush. The dispatch stage issues into it, and it drives the common result bus arbiter.

## Interface
- DATA_WIDTH, 32, operand/result width; ≥ 8.
- LATENCY, 1, pipeline stages from accept to result; ≥ 1.
- TAG_WIDTH, 6, width of the ROB/issue tag carried with each op.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: synchronous, active-high; clock clk.
- flush  in  1  synchronous kill of every in-flight op.
- in_valid  in  1  issue request.
- in_ready  out  1  unit can accept this cycle.
- in_op  in  4  operation code.
- in_tag  in  TAG_WIDTH  tag returned with the result.
- data_0  in  DATA_WIDTH  operand A.
- data_1  in  DATA_WIDTH  operand B, or the shift amount in the low log2(DATA_WIDTH) bits.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  DATA_WIDTH  operation result.
- out_tag  out  TAG_WIDTH  tag of the result.
- idle  out  1  no op in flight and no op being offered.

## Operation
- Opcodes:
  - 0 AND: A&B.
  - 1 OR: A|B.
  - 2 XOR: A^B.
  - 3 ANDN: A&~B.
  - 4 ORN: A|~B.
  - 5 XNOR: ~(A^B).
  - 6 PASSA: A.
  - 7 PASSB: B.
  - 8 SLL, 9 SRL, 10 SRA: shift ops, present only with the shift feature (see Configuration).
  - All other codes: result 0, op still completes normally.
- The result is computed combinationally from the inputs and captured into stage 0 on accept. Stages 1..LATENCY-1 are pure delay registers, each holding valid, result and tag.
- Accept condition: in_valid & in_ready at a rising edge.
- Stage k advances when it holds an op and stage k+1 is empty or advancing. The last stage advances on out_ready.
- in_ready = !rst & !flush & (stage0 empty | stage0 advancing). A full pipeline whose output is consumed each cycle sustains 1 op/cycle.
- out_valid, result and out_tag come directly from the last stage's registers.
- With out_valid=1 and out_ready=0, result and out_tag hold stable.
- idle = (no stage valid) & !in_valid.

## Timing
- Reset clears all stage valid bits and zeroes all result/tag registers. In the cycle after rst is deasserted: out_valid=0, result=0, out_tag=0, in_ready=1, idle=!in_valid.
- rst asserted mid-operation discards every in-flight op; nothing is emitted.
- Latency: an op accepted at edge t presents out_valid=1 after edge t+LATENCY-1, i.e. in the cycle following the LATENCY-th edge counted from and including t, provided there are no stalls. For LATENCY=1, the result is visible the cycle after accept.
- Each stall cycle (out_ready=0 with the last stage full) delays ops behind the bubble-free region by one cycle. Existing bubbles are squeezed out before in_ready drops.
- flush: every valid bit is cleared at that edge, in_ready=0 in the flush cycle, and any input offered that cycle is dropped. out_valid=0 from the next cycle.
- flush together with out_ready=1 and out_valid=1: the handshake completes on that edge, and the consumer treats the result as killed.
- rst has priority over flush.

## Configuration
- FU_LOGIC_SHIFT_EN:
  - Defined: opcodes 8/9/10 perform logical left, logical right and arithmetic right shifts of A by B[$clog2(DATA_WIDTH)-1:0]. The shifter sits in the stage-0 combinational path.
  - Undefined: opcodes 8/9/10 fall into the "other codes" case and return 0, and no shifter logic is synthesised.
  - Handshake and latency are identical in both builds.

## Test plan
- Reset, LATENCY=1: hold rst 2 cycles, release; expect out_valid=0, result=0, in_ready=1. Then issue AND A=0xF0F0_1234, B=0x0FF0_FFFF, tag 5; next cycle expect result=0x00F0_1234, out_tag=5, out_valid=1.
- Back-to-back, LATENCY=3, out_ready=1: issue ops 0..7 with tags 0..7 on consecutive cycles; expect results in order on 8 consecutive cycles starting 3 cycles after the first accept, with in_ready never low.
- Backpressure, LATENCY=3: fill with 3 ops, hold out_ready=0 for 4 cycles. Expect result/out_tag stable, in_ready=0 once all stages are full, and no op lost or duplicated after release.
- Flush: with 2 ops in flight, pulse flush while offering a third op. Expect out_valid=0 on the following cycles, none of the 3 tags ever appearing, and in_ready=1 the cycle after the flush.
- Opcode sweep, A=0xAAAA_5555, B=0x0000_FFFF: expect ANDN=0xAAAA_0000, ORN=0xFFFF_5555, XNOR=0x5555_5555, opcode 15 → 0.
- With FU_LOGIC_SHIFT_EN, A=0x8000_0001, B=4: expect SLL=0x0000_0010, SRL=0x0800_0000, SRA=0xF800_0000. Without the macro, all three return 0.

Source files
------------

// File: rtl/fu_logic_if.sv
// ---------------------------------------------------------------------------
// fu_logic_if -- issue/result handshake bundle for the logic functional unit.
//
// Signals:
//   flush                         kill every in-flight op (driven by issuer)
//   in_valid / in_ready           issue handshake
//   in_op, in_tag, data_0, data_1 issued operation, tag and operands
//   out_valid / out_ready         result handshake towards the result bus
//   result, out_tag               produced value and its issue tag
//   idle                          no op in flight and none being offered
//
// Modports:
//   master -- the dispatch / result-bus side
//   slave  -- the functional unit
// ---------------------------------------------------------------------------
interface fu_logic_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
) ();

  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_op;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic [DATA_WIDTH-1:0] data_0;
  logic [DATA_WIDTH-1:0] data_1;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  idle;

  modport master (
    output flush, in_valid, in_op, in_tag, data_0, data_1, out_ready,
    input  in_ready, out_valid, result, out_tag, idle
  );

  modport slave (
    input  flush, in_valid, in_op, in_tag, data_0, data_1, out_ready,
    output in_ready, out_valid, result, out_tag, idle
  );

endinterface

// File: rtl/fu_logic_pipe.sv
// ---------------------------------------------------------------------------
// fu_logic_pipe -- pipelined multi-operation bitwise functional unit.
//
// The logic result is computed combinationally from the issued operands and
// captured into stage 0 on accept; stages 1..LATENCY-1 are plain delay
// registers (valid, result, tag). Bubbles are squeezed out so a stalled
// output only blocks the contiguous full region behind it.
//
// Parameters:
//   DATA_WIDTH  operand/result width (>= 8)
//   LATENCY     stages from accept to result (>= 1)
//   TAG_WIDTH   issue tag width
//
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset, priority over flush
//   bus   fu_logic_if.slave: flush, issue handshake, result handshake, idle
//
// Build option:
//   FU_LOGIC_SHIFT_EN  when defined, opcodes 8/9/10 are SLL/SRL/SRA of
//                      data_0 by data_1[$clog2(DATA_WIDTH)-1:0]; otherwise
//                      they return 0 like every other unused opcode.
// ---------------------------------------------------------------------------
module fu_logic_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1,
  parameter int TAG_WIDTH  = 6
) (
  input logic      clk,
  input logic      rst,
  fu_logic_if.slave bus
);

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_XOR   = 4'd2,
    OP_ANDN  = 4'd3,
    OP_ORN   = 4'd4,
    OP_XNOR  = 4'd5,
    OP_PASSA = 4'd6,
    OP_PASSB = 4'd7,
    OP_SLL   = 4'd8,
    OP_SRL   = 4'd9,
    OP_SRA   = 4'd10
  } op_e;

`ifdef FU_LOGIC_SHIFT_EN
  localparam int SHAMT_W = $clog2(DATA_WIDTH);
  logic [SHAMT_W-1:0] shamt;
  assign shamt = bus.data_1[SHAMT_W-1:0];
`endif

  // -------------------------------------------------------------------------
  // Stage-0 combinational operation
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] op_result;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    op_result = '0;
    case (op_e'(bus.in_op))
      OP_AND:   op_result = bus.data_0 & bus.data_1;
      OP_OR:    op_result = bus.data_0 | bus.data_1;
      OP_XOR:   op_result = bus.data_0 ^ bus.data_1;
      OP_ANDN:  op_result = bus.data_0 & ~bus.data_1;
      OP_ORN:   op_result = bus.data_0 | ~bus.data_1;
      OP_XNOR:  op_result = ~(bus.data_0 ^ bus.data_1);
      OP_PASSA: op_result = bus.data_0;
      OP_PASSB: op_result = bus.data_1;
`ifdef FU_LOGIC_SHIFT_EN
      OP_SLL:   op_result = bus.data_0 << shamt;
      OP_SRL:   op_result = bus.data_0 >> shamt;
      OP_SRA:   op_result = $unsigned($signed(bus.data_0) >>> shamt);
`endif
      default:  op_result = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Pipeline state
  // -------------------------------------------------------------------------
  logic [LATENCY-1:0]    stage_valid;
  logic [LATENCY-1:0]    stage_adv;
  logic [DATA_WIDTH-1:0] stage_result [LATENCY];
  logic [TAG_WIDTH-1:0]  stage_tag    [LATENCY];

  // What each stage would capture this cycle.
  logic [LATENCY-1:0]    load;
  logic [DATA_WIDTH-1:0] load_result [LATENCY];
  logic [TAG_WIDTH-1:0]  load_tag    [LATENCY];

  logic in_ready_int;
  logic accept;

  // A stage advances unless it and every stage after it are full while the
  // consumer is stalling. Walking from the output back, 'blocked' records
  // whether the contiguous full region ahead is stuck.
  always_comb begin : adv_chain
    logic blocked;
    // NOTE: 'blocked' is a scratch variable updated step by step within one
    // evaluation, so it uses blocking assignments; registers use <= only.
    blocked   = !bus.out_ready;
    stage_adv = '0;
    for (int k = LATENCY - 1; k >= 0; k--) begin
      stage_adv[k] = stage_valid[k] & !blocked;
      blocked      = blocked & stage_valid[k];
    end
  end

  assign in_ready_int = !rst && !bus.flush && (!stage_valid[0] || stage_adv[0]);
  assign accept       = bus.in_valid && in_ready_int;

  for (genvar g = 0; g < LATENCY; g++) begin : g_load
    if (g == 0) begin : g_head
      assign load[g]        = accept;
      assign load_result[g] = op_result;
      assign load_tag[g]    = bus.in_tag;
    end else begin : g_tail
      assign load[g]        = stage_adv[g-1];
      assign load_result[g] = stage_result[g-1];
      assign load_tag[g]    = stage_tag[g-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are reset as well as the valid bits because
      // result/out_tag are architecturally required to read zero after reset.
      for (int k = 0; k < LATENCY; k++) begin
        stage_valid[k]  <= 1'b0;
        stage_result[k] <= '0;
        stage_tag[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < LATENCY; k++) begin
        if (bus.flush) begin
          stage_valid[k] <= 1'b0;
        end else if (load[k]) begin
          stage_valid[k]  <= 1'b1;
          stage_result[k] <= load_result[k];
          stage_tag[k]    <= load_tag[k];
        end else if (stage_adv[k]) begin
          stage_valid[k] <= 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs straight from the last stage
  // -------------------------------------------------------------------------
  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = stage_valid[LATENCY-1];
  assign bus.result    = stage_result[LATENCY-1];
  assign bus.out_tag   = stage_tag[LATENCY-1];
  assign bus.idle      = !(|stage_valid) && !bus.in_valid;

endmodule
